// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_nrd register file and its read mux:
// the default data width and the address range test.
package regfile_pkg;

    // Default data word width in bits.
    localparam int unsigned REGFILE_W_DEF = 32;

    // An address is usable only when it names an existing word.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage : regfile_pkg

// File: rtl/mux_nto1.sv
// mux_nto1: combinational N-to-1 word selector for one read port.
// Returns words[sel], or all zeros when sel addresses a word that does not
// exist (sel >= DEPTH), so out-of-range reads can never alias real storage.
module mux_nto1
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = REGFILE_W_DEF,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] words,
    input  logic [AW-1:0]               sel,
    output logic [WIDTH-1:0]            y
);

    // Select the addressed word, zero when the address is out of range.
    always_comb begin
        // NOTE: y gets a default before any condition so every path assigns it and no latch is inferred.
        y = '0;
        if (addr_valid(32'(sel), DEPTH)) begin
            y = words[sel];
        end
    end

endmodule : mux_nto1

// File: rtl/regfile_nrd.sv
// regfile_nrd: DEPTH x WIDTH register file, one write port, NRD read ports.
// Each read port has a registered one-cycle read with a valid strobe and an
// out-of-range error flag. Writes to non-existent addresses are dropped.
//
// Build option: define REGFILE_NRD_BYPASS_EN to forward write data to a read
// of the same address accepted at the same edge. Without it, such a read
// returns the word stored before the write, and wd has no path to rd.
module regfile_nrd
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = REGFILE_W_DEF,
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_n,
    input  logic [AW-1:0]             add_wr,
    input  logic [WIDTH-1:0]          wd,
    input  logic [NRD-1:0]            rd_req,
    input  logic [NRD-1:0][AW-1:0]    add_rd,
    output logic [NRD-1:0][WIDTH-1:0] rd,
    output logic [NRD-1:0]            rd_valid,
    output logic [NRD-1:0]            rd_err
);

    // Storage words, packed so the whole array can feed each read mux.
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Write is qualified by the active-low enable and the address range.
    logic wr_ok;
    assign wr_ok = !we_n && addr_valid(32'(add_wr), DEPTH);

    // Storage update: async clear, then one word written per enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because reads after reset must return 0; this keeps it in flops, not SRAM macros.
            mem <= '0;
        end else if (wr_ok) begin
            // NOTE: non-blocking so reads at this edge still see the pre-write word.
            mem[add_wr] <= wd;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [WIDTH-1:0] mux_q;
        logic [WIDTH-1:0] rd_next;
        logic             rd_ok;
        logic [WIDTH-1:0] rd_q;
        logic             valid_q;
        logic             err_q;

        mux_nto1 #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_mux (
            .words (mem),
            .sel   (add_rd[p]),
            .y     (mux_q)
        );

        assign rd_ok = addr_valid(32'(add_rd[p]), DEPTH);

`ifdef REGFILE_NRD_BYPASS_EN
        // Same-edge write to the word being read: forward the new data.
        logic bypass_hit;
        assign bypass_hit = wr_ok && (add_wr == add_rd[p]);
        assign rd_next    = bypass_hit ? wd : mux_q;
`else
        assign rd_next = mux_q;
`endif

        // Read register: capture on request, drop valid when idle, hold data and error.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q    <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (rd_req[p]) begin
                rd_q    <= rd_next;
                valid_q <= 1'b1;
                err_q   <= !rd_ok;
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign rd[p]       = rd_q;
        assign rd_valid[p] = valid_q;
        assign rd_err[p]   = err_q;
    end

endmodule : regfile_nrd

// File: tb/tb_regfile_nrd.sv
// Testbench for regfile_nrd. Two instances share one set of inputs:
// u_d8 (DEPTH 8) and u_d6 (DEPTH 6), both 32-bit wide with two read ports.
// Directed tables and sequences use constant expectations; the random phase
// and the reset phase compare against a word-array model of the register file.
module tb_regfile_nrd;

`ifdef REGFILE_NRD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            we_n;
    logic [2:0]      add_wr;
    logic [31:0]     wd;
    logic [1:0]      rd_req;
    logic [1:0][2:0] add_rd;

    logic [1:0][31:0] rd8, rd6;
    logic [1:0]       rd_valid8, rd_valid6, rd_err8, rd_err6;

    regfile_nrd #(.WIDTH(32), .DEPTH(8), .NRD(2)) u_d8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_n     (we_n),
        .add_wr   (add_wr),
        .wd       (wd),
        .rd_req   (rd_req),
        .add_rd   (add_rd),
        .rd       (rd8),
        .rd_valid (rd_valid8),
        .rd_err   (rd_err8)
    );

    regfile_nrd #(.WIDTH(32), .DEPTH(6), .NRD(2)) u_d6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_n     (we_n),
        .add_wr   (add_wr),
        .wd       (wd),
        .rd_req   (rd_req),
        .add_rd   (add_rd),
        .rd       (rd6),
        .rd_valid (rd_valid6),
        .rd_err   (rd_err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: index 0 models the DEPTH 8 instance, 1 the DEPTH 6 one.
    logic [31:0] mm   [2][8];
    logic [31:0] e_rd [2][2];
    logic        e_v  [2][2];
    logic        e_e  [2][2];

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) mm[k][a] = '0;
            for (int p = 0; p < 2; p++) begin
                e_rd[k][p] = '0;
                e_v[k][p]  = 1'b0;
                e_e[k][p]  = 1'b0;
            end
        end
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    task automatic step_model();
        for (int k = 0; k < 2; k++) begin
            int unsigned d;
            int unsigned a;
            d = (k == 0) ? 8 : 6;
            for (int p = 0; p < 2; p++) begin
                a = add_rd[p];
                if (rd_req[p]) begin
                    e_v[k][p] = 1'b1;
                    if (a >= d) begin
                        e_rd[k][p] = '0;
                        e_e[k][p]  = 1'b1;
                    end else begin
                        e_e[k][p]  = 1'b0;
                        e_rd[k][p] = (BYP && !we_n && add_wr == add_rd[p]) ? wd : mm[k][a];
                    end
                end else begin
                    e_v[k][p] = 1'b0;
                end
            end
            if (!we_n && add_wr < d) mm[k][add_wr] = wd;
        end
    endtask

    task automatic apply();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("%s d8 rd%0d", tag, p), rd8[p], e_rd[0][p]);
            check($sformatf("%s d8 valid%0d", tag, p), 32'(rd_valid8[p]), 32'(e_v[0][p]));
            check($sformatf("%s d8 err%0d", tag, p), 32'(rd_err8[p]), 32'(e_e[0][p]));
            check($sformatf("%s d6 rd%0d", tag, p), rd6[p], e_rd[1][p]);
            check($sformatf("%s d6 valid%0d", tag, p), 32'(rd_valid6[p]), 32'(e_v[1][p]));
            check($sformatf("%s d6 err%0d", tag, p), 32'(rd_err6[p]), 32'(e_e[1][p]));
        end
    endtask

    task automatic set_in(input logic w_n, input logic [2:0] aw, input logic [31:0] d,
                          input logic [1:0] req, input logic [2:0] a0, input logic [2:0] a1);
        we_n      = w_n;
        add_wr    = aw;
        wd        = d;
        rd_req    = req;
        add_rd[0] = a0;
        add_rd[1] = a1;
    endtask

    typedef struct {
        logic        we_n;
        logic [2:0]  add_wr;
        logic [31:0] wd;
        logic [1:0]  req;
        logic [2:0]  a0;
        logic [2:0]  a1;
        logic [1:0]  exp_valid;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Vector table: eight writes, then eight dual-port reads (port 1 mirrored).
        for (int i = 0; i < 8; i++) begin
            vecs[i].we_n      = 1'b0;
            vecs[i].add_wr    = 3'(i);
            vecs[i].wd        = 32'hA5A5_0000 + 32'(i);
            vecs[i].req       = 2'b00;
            vecs[i].a0        = 3'd0;
            vecs[i].a1        = 3'd0;
            vecs[i].exp_valid = 2'b00;
            vecs[i].exp_rd0   = 32'h0;
            vecs[i].exp_rd1   = 32'h0;
            vecs[8+i].we_n      = 1'b1;
            vecs[8+i].add_wr    = 3'd0;
            vecs[8+i].wd        = 32'h0;
            vecs[8+i].req       = 2'b11;
            vecs[8+i].a0        = 3'(i);
            vecs[8+i].a1        = 3'(7 - i);
            vecs[8+i].exp_valid = 2'b11;
            vecs[8+i].exp_rd0   = 32'hA5A5_0000 + 32'(i);
            vecs[8+i].exp_rd1   = 32'hA5A5_0000 + 32'(7 - i);
        end

        // Power-on reset state.
        rst_n = 1'b0;
        set_in(1'b1, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0);
        reset_model();
        #2;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Write all words, then read them back on both ports.
        for (int j = 0; j < 16; j++) begin
            set_in(vecs[j].we_n, vecs[j].add_wr, vecs[j].wd, vecs[j].req, vecs[j].a0, vecs[j].a1);
            apply();
            check($sformatf("tbl%0d valid", j), 32'(rd_valid8), 32'(vecs[j].exp_valid));
            check($sformatf("tbl%0d rd0", j), rd8[0], vecs[j].exp_rd0);
            check($sformatf("tbl%0d rd1", j), rd8[1], vecs[j].exp_rd1);
        end

        // Out of range on the DEPTH 6 instance: dropped write, error reads.
        set_in(1'b0, 3'd7, 32'hDEAD_BEEF, 2'b00, 3'd0, 3'd0);
        apply();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'd0, 32'h0, 2'b11, 3'(2*i), 3'(2*i + 1));
            apply();
            check($sformatf("oor keep%0d", 2*i), rd6[0], 32'hA5A5_0000 + 32'(2*i));
            check($sformatf("oor keep%0d", 2*i + 1), rd6[1], 32'hA5A5_0000 + 32'(2*i + 1));
            check("oor keep err", 32'(rd_err6), 32'h0);
        end
        set_in(1'b1, 3'd0, 32'h0, 2'b11, 3'd6, 3'd7);
        apply();
        check("oor a6 rd", rd6[0], 32'h0);
        check("oor a7 rd", rd6[1], 32'h0);
        check("oor valid", 32'(rd_valid6), 32'h3);
        check("oor err", 32'(rd_err6), 32'h3);
        check("d8 last word", rd8[1], 32'hDEAD_BEEF);
        check("d8 a6 err", 32'(rd_err8), 32'h0);
        set_in(1'b1, 3'd0, 32'h0, 2'b01, 3'd2, 3'd0);
        apply();
        check("oor rec rd", rd6[0], 32'hA5A5_0002);
        check("oor rec err", 32'(rd_err6), 32'h2);
        check("oor rec valid", 32'(rd_valid6), 32'h1);

        // Hold: one request then three idle cycles.
        set_in(1'b1, 3'd0, 32'h0, 2'b01, 3'd5, 3'd0);
        apply();
        check("hold v0", 32'(rd_valid8[0]), 32'h1);
        check("hold rd0", rd8[0], 32'hA5A5_0005);
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0);
            apply();
            check($sformatf("hold v%0d", i), 32'(rd_valid8[0]), 32'h0);
            check($sformatf("hold rd%0d", i), rd8[0], 32'hA5A5_0005);
        end
        // Back-to-back reads at 0, 1, 2.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'd0, 32'h0, 2'b01, 3'(i), 3'd0);
            apply();
            check($sformatf("b2b%0d rd", i), rd8[0], 32'hA5A5_0000 + 32'(i));
            check($sformatf("b2b%0d valid", i), 32'(rd_valid8[0]), 32'h1);
        end

        // Collision: read and write address 3 at the same edge.
        set_in(1'b0, 3'd3, 32'h1111_1111, 2'b00, 3'd0, 3'd0);
        apply();
        set_in(1'b0, 3'd3, 32'h2222_2222, 2'b01, 3'd3, 3'd0);
        apply();
        check("coll d8", rd8[0], BYP ? 32'h2222_2222 : 32'h1111_1111);
        check("coll d6", rd6[0], BYP ? 32'h2222_2222 : 32'h1111_1111);
        set_in(1'b1, 3'd0, 32'h0, 2'b11, 3'd3, 3'd3);
        apply();
        check("coll after p0", rd8[0], 32'h2222_2222);
        check("coll after p1", rd8[1], 32'h2222_2222);
        check("coll after d6", rd6[0], 32'h2222_2222);

        // Reset asserted mid-cycle while rd_valid is high, with a read pending.
        set_in(1'b1, 3'd0, 32'h0, 2'b11, 3'd3, 3'd0);
        apply();
        check("pre-rst valid", 32'(rd_valid8), 32'h3);
        #3;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_all("rst async");
        @(posedge clk);
        #1;
        check_all("rst held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 3'd0, 32'h0, 2'b11, 3'(i), 3'(7 - i));
            apply();
            check_all($sformatf("post-rst a%0d", i));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            apply();
            check_all($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_nrd
